// File: rtl/intr_gen.sv
// -----------------------------------------------------------------------------
// intr_gen
//
// Interrupt generation stage behind the test register bank. Per-source events
// are captured into a raw status vector, which is then qualified by the mask
// and the non-maskable override. The result drives one interrupt line to the
// host. That line is either level-triggered or a fixed-width pulse.
//
// Configuration macro:
//   INTR_GEN_EVT_EDGE_EN  defined   -> raw bits are set on the rising edge of
//                                      i_intr_evt (a held event sets once)
//                         undefined -> raw bits are set while i_intr_evt is
//                                      high (a held event overrides W1C)
//
// Ports:
//   i_clk            clock, all logic on the rising edge
//   i_rst            synchronous active-high reset
//   i_intr_evt       per-source event request from functional logic
//   i_intr_msk       per-source mask (1 = masked)
//   i_intr_type      0 = level-triggered, 1 = pulse-triggered
//   i_intr_width     pulse width in cycles (0 behaves as 1)
//   i_w1c_vld        write strobe to RAW_INTR_STAT
//   i_w1c_data       write data, 1 clears the raw bit
//   i_init_clr       one-cycle initialisation clear (bits selected by INIT_CLR)
//   o_raw_intr_stat  registered raw status
//   o_intr_stat      masked status: raw & (~msk | NON_MASKABLE), combinational
//   o_intr           registered interrupt line to the host
// -----------------------------------------------------------------------------
module intr_gen #(
  parameter int                  INTR_NUM            = 2,
  parameter int                  INTR_PULSE_WIDTH_BW = 8,
  parameter logic [INTR_NUM-1:0] NON_MASKABLE        = 'b01,
  parameter logic [INTR_NUM-1:0] INIT_CLR            = 'b01
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [INTR_NUM-1:0]            i_intr_evt,
  input  logic [INTR_NUM-1:0]            i_intr_msk,
  input  logic                           i_intr_type,
  input  logic [INTR_PULSE_WIDTH_BW-1:0] i_intr_width,
  input  logic                           i_w1c_vld,
  input  logic [INTR_NUM-1:0]            i_w1c_data,
  input  logic                           i_init_clr,
  output logic [INTR_NUM-1:0]            o_raw_intr_stat,
  output logic [INTR_NUM-1:0]            o_intr_stat,
  output logic                           o_intr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  logic [INTR_NUM-1:0]            raw_q, raw_d;
  logic [INTR_NUM-1:0]            stat_q, stat_d;
  logic [INTR_NUM-1:0]            evt_qual;
  logic [INTR_NUM-1:0]            new_bits;
  logic [INTR_PULSE_WIDTH_BW-1:0] cnt_q, cnt_d;
  logic [INTR_PULSE_WIDTH_BW-1:0] cnt_load;
  logic                           pend_q, pend_d;
  logic                           intr_q, intr_d;
  state_e                         state_q, state_d;

  // ---------------------------------------------------------------------------
  // Event qualifier
  // ---------------------------------------------------------------------------
`ifdef INTR_GEN_EVT_EDGE_EN
  logic [INTR_NUM-1:0] evt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) evt_q <= '0;
    else       evt_q <= i_intr_evt;
  end

  assign evt_qual = i_intr_evt & ~evt_q;
`else
  assign evt_qual = i_intr_evt;
`endif

  // ---------------------------------------------------------------------------
  // Raw status: a set has priority over W1C, and W1C has priority over init
  // clear. Each bit resolves independently.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    raw_d = raw_q;
    for (int b = 0; b < INTR_NUM; b++) begin
      if (evt_qual[b])                    raw_d[b] = 1'b1;
      else if (i_w1c_vld && i_w1c_data[b]) raw_d[b] = 1'b0;
      else if (i_init_clr && INIT_CLR[b])  raw_d[b] = 1'b0;
    end
  end

  assign o_intr_stat = raw_q & (~i_intr_msk | NON_MASKABLE);
  assign stat_d      = o_intr_stat;

  // A bit is "new" in the first cycle it appears in the masked status. This
  // covers a fresh event and also unmasking an already-set raw bit.
  assign new_bits = o_intr_stat & ~stat_q;

  // A width of 0 behaves as 1. The counter holds the number of high cycles
  // remaining after the current one.
  assign cnt_load = (i_intr_width == '0) ? '0
                                         : i_intr_width - INTR_PULSE_WIDTH_BW'(1);

  // ---------------------------------------------------------------------------
  // Output FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    intr_d  = 1'b0;

    if (!i_intr_type) begin
      // Level mode. This also aborts any pulse in flight when the mode
      // switches, so the line takes the level value on the next cycle.
      state_d = ST_IDLE;
      pend_d  = 1'b0;
      intr_d  = |o_intr_stat;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|new_bits) begin
            cnt_d   = cnt_load;
            intr_d  = 1'b1;
            state_d = ST_PULSE;
          end
        end
        ST_PULSE: begin
          // A source that arrives mid-pulse is remembered and served after
          // the mandatory one-cycle gap.
          if (|new_bits) pend_d = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_GAP;
          end else begin
            cnt_d  = cnt_q - INTR_PULSE_WIDTH_BW'(1);
            intr_d = 1'b1;
          end
        end
        ST_GAP: begin
          if (pend_q || (|new_bits)) begin
            pend_d  = 1'b0;
            cnt_d   = cnt_load;
            intr_d  = 1'b1;
            state_d = ST_PULSE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples its pre-edge value, whatever the statement order.
    if (i_rst) begin
      raw_q   <= '0;
      stat_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      intr_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      raw_q   <= raw_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      intr_q  <= intr_d;
      state_q <= state_d;
    end
  end

  assign o_raw_intr_stat = raw_q;
  assign o_intr          = intr_q;

endmodule
